// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection with a small circular return-address stack.
// Optional misalignment flag output built when PC_MISALIGN_CHK_EN is defined.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [31:0]     TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic [XLEN-1:0] call_target,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misalign
`endif
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    RAS_HOLD,
    RAS_PUSH,
    RAS_POP,
    RAS_REPL
  } ras_op_e;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   top_q;
  logic [CW-1:0]   count_q;
  logic            underflow_q;
  logic            underflow_d;
  ras_op_e         ras_op;

  assign pc_out        = pc_q;
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == CW'(RAS_DEPTH));
  assign ras_underflow = underflow_q;
  assign seq_pc        = pc_q + XLEN'(STEP);

  always_comb begin
    pc_next     = seq_pc;
    ras_op      = RAS_HOLD;
    underflow_d = 1'b0;
    if (trap) begin
      pc_next = XLEN'(TRAP_VEC);
    end else if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (call_valid && ret_valid) begin
      // Call and return cancel out: the top entry is rewritten in place.
      pc_next = call_target;
      ras_op  = RAS_REPL;
    end else if (call_valid) begin
      pc_next = call_target;
      ras_op  = RAS_PUSH;
    end else if (ret_valid) begin
      if (ras_empty) begin
        underflow_d = 1'b1;
      end else begin
        pc_next = ras_q[top_q];
        ras_op  = RAS_POP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      top_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      underflow_q <= underflow_d;
      unique case (ras_op)
        RAS_PUSH: begin
          // Full push wraps onto the oldest entry; count saturates.
          ras_q[top_q + PW'(1)] <= seq_pc;
          top_q                 <= top_q + PW'(1);
          if (!ras_full) count_q <= count_q + CW'(1);
        end
        RAS_POP: begin
          top_q   <= top_q - PW'(1);
          count_q <= count_q - CW'(1);
        end
        RAS_REPL: begin
          ras_q[top_q] <= seq_pc;
          if (ras_empty) count_q <= CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= ((pc_next % XLEN'(STEP)) != '0);
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic,
// compared against a queue-based return-stack model.
module tb_pc_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_V = 32'h0;
  localparam logic [31:0] TRAP_V  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        trap = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call_valid = 1'b0;
  logic [31:0] call_target = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_underflow;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign;
`endif

  pc_unit #(
    .XLEN(32),
    .STEP(4),
    .RESET_VEC(RESET_V),
    .TRAP_VEC(TRAP_V),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .trap(trap),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .call_valid(call_valid),
    .call_target(call_target),
    .ret_valid(ret_valid),
    .pc_out(pc_out),
    .pc_next(pc_next),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_underflow(ras_underflow)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: current PC plus a bounded list of return addresses (newest last).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit tr, input bit rv,
                      input logic [31:0] rt, input bit cv, input logic [31:0] ct,
                      input bit rtv);
    logic [31:0] exp_next;
    logic [31:0] seq;
    bit          exp_uf;
    @(negedge clk);
    rst = r; stall = st; trap = tr; redirect_valid = rv; redirect_target = rt;
    call_valid = cv; call_target = ct; ret_valid = rtv;
    #1;
    seq    = m_pc + 32'd4;
    exp_uf = 1'b0;
    if (r) begin
      exp_next = RESET_V;
      m_ras.delete();
    end else begin
      check("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
      check("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
      if (tr) exp_next = TRAP_V;
      else if (rv) exp_next = rt;
      else if (st) exp_next = m_pc;
      else if (cv && rtv) begin
        exp_next = ct;
        if (m_ras.size() == 0) m_ras.push_back(seq);
        else m_ras[m_ras.size() - 1] = seq;
      end else if (cv) begin
        exp_next = ct;
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (rtv) begin
        if (m_ras.size() == 0) begin
          exp_next = seq;
          exp_uf   = 1'b1;
        end else begin
          exp_next = m_ras.pop_back();
        end
      end else exp_next = seq;
      check("pc_next", pc_next, exp_next);
    end
    @(posedge clk);
    #1;
    m_pc = exp_next;
    check("pc_out", pc_out, m_pc);
    check("ras_underflow", {31'b0, ras_underflow}, {31'b0, exp_uf});
`ifdef PC_MISALIGN_CHK_EN
    check("misalign", {31'b0, misalign}, {31'b0, !r && (m_pc[1:0] != 2'b00)});
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    m_pc = '0;
    // Reset, then free run 4, 8, 12
    step(1, 0, 0, 0, '0, 0, '0, 0);
    check("reset_pc", pc_out, 32'h0);
    for (int i = 0; i < 3; i++) idle();
    check("free_run_pc", pc_out, 32'hC);
    check("empty_after_run", {31'b0, ras_empty}, 32'd1);

    // Stall while calling, then redirect during stall
    idle();
    step(0, 1, 0, 0, '0, 1, 32'h300, 0);
    step(0, 1, 0, 0, '0, 1, 32'h300, 0);
    check("stall_hold", pc_out, 32'h10);
    step(0, 1, 0, 1, 32'h200, 0, '0, 0);
    check("redirect_in_stall", pc_out, 32'h200);

    // Nested call / return
    step(0, 0, 0, 1, 32'h20, 0, '0, 0);
    step(0, 0, 0, 0, '0, 1, 32'h400, 0);
    idle();
    step(0, 0, 0, 0, '0, 1, 32'h800, 0);
    step(0, 0, 0, 0, '0, 0, '0, 1);
    check("ret1", pc_out, 32'h408);
    step(0, 0, 0, 0, '0, 0, '0, 1);
    check("ret2", pc_out, 32'h24);

    // Overflow wrap then underflow
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, 1, 32'h1000 + 32'(i) * 32'h100, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, 0, '0, 1);
    idle();
    idle();

    // Simultaneous call+ret, including from empty
    step(0, 0, 0, 0, '0, 1, 32'h2000, 1);
    step(0, 0, 0, 0, '0, 1, 32'h3000, 1);
    step(0, 0, 0, 0, '0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 0, '0, 1);

    // Priority: trap beats redirect and call; reset beats trap
    step(0, 0, 0, 0, '0, 1, 32'h500, 0);
    step(0, 0, 1, 1, 32'h700, 1, 32'h900, 0);
    check("trap_prio", pc_out, TRAP_V);
    step(1, 0, 1, 0, '0, 0, '0, 0);
    check("rst_over_trap", pc_out, RESET_V);

    // Wrap at 2^32 and misaligned redirect
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0);
    idle();
    check("pc_wrap", pc_out, 32'h0);
    step(0, 0, 0, 1, 32'h102, 0, '0, 0);
    idle();
    step(0, 0, 0, 1, 32'h200, 0, '0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rt;
      logic [31:0] ct;
      rt = $urandom();
      ct = $urandom();
      if ($urandom_range(0, 9) != 0) begin
        rt[1:0] = 2'b00;
        ct[1:0] = 2'b00;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0, rt, $urandom_range(0, 3) == 0, ct,
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
